// File: rtl/wb_buffer.sv
// -----------------------------------------------------------------------------
// wb_buffer
//
// Writeback buffer between the MEM stage and the register file write port.
// Retiring results from MEM are formatted (load byte/halfword extraction and
// sign/zero extension), queued in a small FIFO, and drained one per cycle to
// the register file. Entries that are queued but not yet written are visible
// to the ID stage through two forwarding lookup ports; the youngest matching
// entry supplies the data.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   PTR_W   log2(DEPTH)
//
// Ports
//   clock        in   system clock, all state updates on posedge
//   reset_n      in   synchronous reset, active-low
//   mem_valid    in   MEM presents a retiring result
//   mem_ready    out  buffer can accept this cycle (depends on state only)
//   mem_wb_en    in   instruction writes rd
//   mem_rd       in   destination register
//   mem_is_load  in   mem_data is a raw aligned load word
//   mem_funct3   in   load width/sign select
//   mem_off      in   byte offset of the load address
//   mem_data     in   ALU result or raw load word
//   wb_hold      in   suppresses writeback this cycle
//   write        out  register file write enable
//   regw_addr    out  register file write address (0 when not writing)
//   regw_data    out  register file write data (0 when not writing)
//   fwd_addr1/2  in   forwarding lookup addresses
//   fwd_hit1/2   out  lookup matched a queued entry
//   fwd_data1/2  out  data of youngest match (0 when no hit)
//   empty        out  no queued entries
// -----------------------------------------------------------------------------
module wb_buffer #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic        clock,
    input  logic        reset_n,

    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_rd,
    input  logic        mem_is_load,
    input  logic [2:0]  mem_funct3,
    input  logic [1:0]  mem_off,
    input  logic [31:0] mem_data,

    input  logic        wb_hold,
    output logic        write,
    output logic [4:0]  regw_addr,
    output logic [31:0] regw_data,

    input  logic [4:0]  fwd_addr1,
    output logic        fwd_hit1,
    output logic [31:0] fwd_data1,
    input  logic [4:0]  fwd_addr2,
    output logic        fwd_hit2,
    output logic [31:0] fwd_data2,

    output logic        empty
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // -------------------------------------------------------------------------
    // Load formatting. Non-load results pass through untouched; reserved
    // funct3 encodings also return the raw word so nothing is silently mangled.
    // -------------------------------------------------------------------------
    function automatic logic [7:0] pick_byte(input logic [31:0] raw,
                                             input logic [1:0]  off);
        logic [7:0] b;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        return b;
    endfunction

    function automatic logic [15:0] pick_half(input logic [31:0] raw,
                                              input logic        hi);
        // The low offset bit is ignored: halfword loads are aligned.
        return hi ? raw[31:16] : raw[15:0];
    endfunction

    function automatic logic [31:0] format_load(input logic        is_load,
                                                input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = pick_byte(raw, off);
        h   = pick_half(raw, off[1]);
        res = raw;
        if (is_load) begin
            case (funct3)
                F3_LB:   res = {{24{b[7]}}, b};
                F3_LBU:  res = {24'b0, b};
                F3_LH:   res = {{16{h[15]}}, h};
                F3_LHU:  res = {16'b0, h};
                F3_LW:   res = raw;
                default: res = raw;
            endcase
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Storage. Entry payload is not reset: validity is tracked by valid_q and
    // count_q, which are the only things reset has to clear.
    // -------------------------------------------------------------------------
    logic [31:0]      data_q [DEPTH];
    logic [4:0]       rd_q   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic        accept;
    logic        store;
    logic        pop;
    logic [31:0] enq_data;

    // Ready depends on registered state only, so there is no combinational
    // path from wb_hold or the drain side back into MEM.
    assign mem_ready = reset_n && (count_q < FULL_CNT);
    assign accept    = mem_valid && mem_ready;
    // Results that do not target a real register are consumed but not queued.
    assign store     = accept && mem_wb_en && (mem_rd != 5'd0);
    assign pop       = write;
    assign enq_data  = format_load(mem_is_load, mem_funct3, mem_off, mem_data);

    // -------------------------------------------------------------------------
    // Drain side: the head is presented and popped in the same cycle the
    // register file samples it.
    // -------------------------------------------------------------------------
    assign write     = reset_n && (count_q != '0) && !wb_hold;
    assign regw_addr = write ? rd_q[rd_ptr_q]   : 5'd0;
    assign regw_data = write ? data_q[rd_ptr_q] : 32'd0;
    assign empty     = !reset_n || (count_q == '0);

    // -------------------------------------------------------------------------
    // Next-state for pointers, count and valid bits
    // -------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;

        if (pop) begin
            rd_ptr_d          = rd_ptr_q + PTR_ONE;
            valid_d[rd_ptr_q] = 1'b0;
        end
        if (store) begin
            wr_ptr_d          = wr_ptr_q + PTR_ONE;
            valid_d[wr_ptr_q] = 1'b1;
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (store) begin
            data_q[wr_ptr_q] <= enq_data;
            rd_q[wr_ptr_q]   <= mem_rd;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding lookup. Entries are walked from head (oldest) towards the
    // tail so that a later match overrides an earlier one: youngest wins.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_data1 = 32'd0;
        if (reset_n && (fwd_addr1 != 5'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if (valid_q[idx] && (rd_q[idx] == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
            end
        end
    end

    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = 32'd0;
        if (reset_n && (fwd_addr2 != 5'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr_q + PTR_W'(i);
                if (valid_q[idx] && (rd_q[idx] == fwd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_buffer.sv
module tb_wb_buffer;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n;
    logic        mem_valid, mem_ready, mem_wb_en, mem_is_load;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_off;
    logic [31:0] mem_data;
    logic        wb_hold, write;
    logic [4:0]  regw_addr;
    logic [31:0] regw_data;
    logic [4:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        empty;

    wb_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wb_en(mem_wb_en),
        .mem_rd(mem_rd), .mem_is_load(mem_is_load), .mem_funct3(mem_funct3),
        .mem_off(mem_off), .mem_data(mem_data),
        .wb_hold(wb_hold), .write(write), .regw_addr(regw_addr), .regw_data(regw_data),
        .fwd_addr1(fwd_addr1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_addr2(fwd_addr2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .empty(empty)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    // Scoreboard: contents of the buffer as the register file should see them.
    ent_t sb[$];
    ent_t pend;          // expected entry for the item currently presented
    logic pend_store;    // presented item should be queued once accepted
    logic acc_n;         // item presented this cycle is accepted at the next edge

    int tests = 0;
    int fails = 0;

    function automatic void chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference load formatting written as shift-and-extend arithmetic.
    function automatic logic [31:0] ref_fmt(input logic ld, input logic [2:0] f3,
                                            input logic [1:0] off, input logic [31:0] raw);
        logic [31:0] b, h;
        b = raw >> {off, 3'b000};
        h = raw >> {off[1], 4'b0000};
        if (!ld) return raw;
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b100:  return {24'b0, b[7:0]};
            3'b001:  return {{16{h[15]}}, h[15:0]};
            3'b101:  return {16'b0, h[15:0]};
            default: return raw;
        endcase
    endfunction

    // Youngest matching queued entry, searched from the tail backwards.
    function automatic void ref_fwd(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (a != 5'd0) begin
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].rd == a) begin
                    h = 1'b1;
                    d = sb[i].data;
                    break;
                end
            end
        end
    endfunction

    // Monitor: compare every output each cycle against the scoreboard, then
    // retire/enqueue at the following edge.
    logic        m_rst, m_exp_w, m_st, m_h;
    logic [31:0] m_d;
    int          m_sz;
    ent_t        m_pe;

    always begin
        @(negedge clock);
        m_rst   = reset_n;
        m_sz    = sb.size();
        m_exp_w = m_rst && (m_sz != 0) && !wb_hold;
        chk1("mem_ready", mem_ready, m_rst && (m_sz < DEPTH));
        chk1("empty", empty, !m_rst || (m_sz == 0));
        chk1("write", write, m_exp_w);
        if (m_exp_w) begin
            chk32("regw_addr", 32'(regw_addr), 32'(sb[0].rd));
            chk32("regw_data", regw_data, sb[0].data);
        end else begin
            chk32("regw_addr_idle", 32'(regw_addr), 32'd0);
            chk32("regw_data_idle", regw_data, 32'd0);
        end
        if (m_rst) ref_fwd(fwd_addr1, m_h, m_d); else begin m_h = 1'b0; m_d = 32'd0; end
        chk1("fwd_hit1", fwd_hit1, m_h);
        chk32("fwd_data1", fwd_data1, m_d);
        if (m_rst) ref_fwd(fwd_addr2, m_h, m_d); else begin m_h = 1'b0; m_d = 32'd0; end
        chk1("fwd_hit2", fwd_hit2, m_h);
        chk32("fwd_data2", fwd_data2, m_d);
        acc_n = mem_valid && m_rst && (m_sz < DEPTH);
        m_st  = pend_store;
        m_pe  = pend;
        @(posedge clock);
        if (!m_rst) begin
            sb.delete();
        end else begin
            if (m_exp_w) void'(sb.pop_front());
            if (acc_n && m_st) sb.push_back(m_pe);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic present(input logic en, input logic [4:0] rd, input logic ld,
                           input logic [2:0] f3, input logic [1:0] off,
                           input logic [31:0] raw, input logic [31:0] exp);
        mem_valid   = 1'b1;
        mem_wb_en   = en;
        mem_rd      = rd;
        mem_is_load = ld;
        mem_funct3  = f3;
        mem_off     = off;
        mem_data    = raw;
        pend        = '{rd: rd, data: exp};
        pend_store  = en && (rd != 5'd0);
    endtask

    task automatic wait_acc(input logic rnd);
        int k;
        k = 0;
        forever begin
            @(posedge clock);
            if (acc_n) break;
            k++;
            if (k > 100) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
                break;
            end
            #1;
            if (rnd) begin
                wb_hold   = ($urandom_range(0, 3) == 0);
                fwd_addr1 = 5'($urandom_range(0, 7));
                fwd_addr2 = 5'($urandom_range(0, 7));
            end
        end
        #1;
        mem_valid  = 1'b0;
        pend_store = 1'b0;
    endtask

    task automatic send(input logic en, input logic [4:0] rd, input logic ld,
                        input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] raw, input logic [31:0] exp);
        present(en, rd, ld, f3, off, raw, exp);
        wait_acc(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        en, ld;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] raw;

        // Reset held with a valid item presented: nothing may be accepted.
        reset_n     = 1'b0;
        wb_hold     = 1'b0;
        fwd_addr1   = 5'd5;
        fwd_addr2   = 5'd0;
        mem_valid   = 1'b1;
        mem_wb_en   = 1'b1;
        mem_rd      = 5'd5;
        mem_is_load = 1'b0;
        mem_funct3  = 3'b000;
        mem_off     = 2'd0;
        mem_data    = 32'hDEAD_BEEF;
        pend        = '{rd: 5'd5, data: 32'hDEAD_BEEF};
        pend_store  = 1'b1;
        acc_n       = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n    = 1'b1;
        mem_valid  = 1'b0;
        pend_store = 1'b0;
        idle(2);

        // ALU pass-through and single-cycle latency.
        send(1'b1, 5'd5, 1'b0, 3'b000, 2'd0, 32'h1234_5678, 32'h1234_5678);
        idle(2);

        // Load formatting on a fixed raw word.
        send(1'b1, 5'd10, 1'b1, 3'b000, 2'd0, 32'h8001_F0A5, 32'hFFFF_FFA5);
        send(1'b1, 5'd11, 1'b1, 3'b100, 2'd2, 32'h8001_F0A5, 32'h0000_0001);
        send(1'b1, 5'd12, 1'b1, 3'b001, 2'd2, 32'h8001_F0A5, 32'hFFFF_8001);
        send(1'b1, 5'd13, 1'b1, 3'b101, 2'd0, 32'h8001_F0A5, 32'h0000_F0A5);
        send(1'b1, 5'd14, 1'b1, 3'b010, 2'd3, 32'h8001_F0A5, 32'h8001_F0A5);
        send(1'b1, 5'd15, 1'b1, 3'b111, 2'd1, 32'h8001_F0A5, 32'h8001_F0A5);
        idle(3);

        // Full while held: third item stalls until the first pop.
        #0 wb_hold = 1'b1;
        send(1'b1, 5'd3, 1'b0, 3'b000, 2'd0, 32'h0000_0333, 32'h0000_0333);
        send(1'b1, 5'd4, 1'b0, 3'b000, 2'd0, 32'h0000_0444, 32'h0000_0444);
        present(1'b1, 5'd6, 1'b0, 3'b000, 2'd0, 32'h0000_0666, 32'h0000_0666);
        idle(3);
        wb_hold = 1'b0;
        wait_acc(1'b0);
        idle(3);

        // Forwarding: youngest match wins, dropped items never appear.
        wb_hold   = 1'b1;
        fwd_addr1 = 5'd7;
        fwd_addr2 = 5'd9;
        send(1'b1, 5'd7, 1'b0, 3'b000, 2'd0, 32'h0000_000A, 32'h0000_000A);
        send(1'b1, 5'd0, 1'b0, 3'b000, 2'd0, 32'h0000_0F00, 32'h0000_0F00);
        send(1'b0, 5'd9, 1'b0, 3'b000, 2'd0, 32'h0000_0900, 32'h0000_0900);
        send(1'b1, 5'd7, 1'b0, 3'b000, 2'd0, 32'h0000_000B, 32'h0000_000B);
        idle(1);
        fwd_addr2 = 5'd0;
        idle(2);
        wb_hold = 1'b0;
        idle(3);

        // Reset in the middle of a drain discards queued results.
        wb_hold = 1'b1;
        send(1'b1, 5'd20, 1'b0, 3'b000, 2'd0, 32'h0000_2020, 32'h0000_2020);
        send(1'b1, 5'd21, 1'b0, 3'b000, 2'd0, 32'h0000_2121, 32'h0000_2121);
        wb_hold = 1'b0;
        idle(1);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(3);

        // Randomized traffic with random hold, lookups and occasional reset.
        for (int it = 0; it < 400; it++) begin
            wb_hold   = ($urandom_range(0, 3) == 0);
            fwd_addr1 = 5'($urandom_range(0, 7));
            fwd_addr2 = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                reset_n = 1'b0;
                idle(1);
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 9) < 7) begin
                en  = ($urandom_range(0, 7) != 0);
                rd  = 5'($urandom_range(0, 7));
                ld  = 1'($urandom_range(0, 1));
                f3  = 3'($urandom_range(0, 7));
                off = 2'($urandom_range(0, 3));
                raw = $urandom;
                present(en, rd, ld, f3, off, raw, ref_fmt(ld, f3, off, raw));
                wait_acc(1'b1);
            end else begin
                idle(1);
            end
        end

        wb_hold = 1'b0;
        idle(6);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
